// File: rtl/nibble_byte_packer.sv
// nibble_byte_packer: packs pairs of 4-bit slices into bytes over valid/ready.
// Holds one partial nibble plus one output byte; flush pads a lone nibble with 4'h0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     nibble handshake, in_nib carries the slice
//   hi_first              order of the pair, sampled with the first nibble
//   flush                 complete a pending half byte with a zero pad nibble
//   out_valid/out_ready   byte handshake, out_byte carries the byte
//   out_padded            out_byte was completed by flush
//   byte_cnt              output handshake count, wraps modulo 2**CNT_W
//   out_parity            ^out_byte, only with NIBBLE_PACKER_PARITY_EN defined
//
// Build option: define NIBBLE_PACKER_PARITY_EN to add the out_parity port.
module nibble_byte_packer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_nib,
    input  logic             hi_first,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic             out_padded,
`ifdef NIBBLE_PACKER_PARITY_EN
    output logic             out_parity,
`endif
    output logic [CNT_W-1:0] byte_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] nib_q;
    logic       order_q;
    logic       in_fire;
    logic       out_fire;
    logic       load_pair;
    logic       load_pad;
    logic [3:0] second;
    logic [7:0] new_byte;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign load_pair = (state == HALF) && in_fire;
    // A flush only counts when no nibble is taken in the same cycle.
    assign load_pad  = (state == HALF) && !in_fire && flush;

    // Second slot is either the incoming nibble or the zero pad.
    assign second    = load_pair ? in_nib : 4'h0;
    assign new_byte  = order_q ? {nib_q, second} : {second, nib_q};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: begin
                if (in_fire) state_nxt = HALF;
            end
            HALF: begin
                if (load_pair || load_pad) state_nxt = FULL;
            end
            FULL: begin
                if (out_fire) state_nxt = in_fire ? HALF : EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            EMPTY: in_ready = 1'b1;
            HALF:  in_ready = 1'b1;
            FULL: begin
                out_valid = 1'b1;
                // Room frees up in the same cycle the byte drains.
                in_ready  = out_ready;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nib_q      <= 4'h0;
            order_q    <= 1'b0;
            out_byte   <= 8'h00;
            out_padded <= 1'b0;
            byte_cnt   <= '0;
        end else begin
            // First nibble of a pair: taken in EMPTY or while draining FULL.
            if (in_fire && (state != HALF)) begin
                nib_q   <= in_nib;
                order_q <= hi_first;
            end
            if (load_pair || load_pad) begin
                out_byte   <= new_byte;
                out_padded <= load_pad;
            end
            if (out_fire) begin
                byte_cnt <= byte_cnt + CNT_W'(1);
            end
        end
    end

`ifdef NIBBLE_PACKER_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
        end else if (load_pair || load_pad) begin
            out_parity <= ^new_byte;
        end
    end
`endif

endmodule

// File: tb/tb_nibble_byte_packer.sv
// tb_nibble_byte_packer: directed plus random stimulus for nibble_byte_packer.
// Expected bytes come from a pair/queue model of the packing rules.
module tb_nibble_byte_packer;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_nib;
    logic             hi_first;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_byte;
    logic             out_padded;
    logic [CNT_W-1:0] byte_cnt;
`ifdef NIBBLE_PACKER_PARITY_EN
    logic             out_parity;
`endif

    int total = 0;
    int bad   = 0;

    // Model: a pending first nibble and a one-deep byte queue.
    bit       m_half;
    int       m_first;
    bit       m_ord;
    int       m_q[$];
    int       m_cnt;

    nibble_byte_packer #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_nib     (in_nib),
        .hi_first   (hi_first),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .out_padded (out_padded),
`ifdef NIBBLE_PACKER_PARITY_EN
        .out_parity (out_parity),
`endif
        .byte_cnt   (byte_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int form(input int first, input int second, input bit ord);
        return ord ? first * 16 + second : second * 16 + first;
    endfunction

    task automatic model_reset();
        m_half  = 0;
        m_first = 0;
        m_ord   = 0;
        m_q.delete();
        m_cnt   = 0;
    endtask

    // Called at a falling edge: drive, check, advance model, run one cycle.
    task automatic drive(input bit v, input int nib, input bit hf,
                         input bit fl, input bit ordy);
        bit rdy;
        bit full;
        int b;
        in_valid  = v;
        in_nib    = 4'(nib);
        hi_first  = hf;
        flush     = fl;
        out_ready = ordy;
        #1;
        full = (m_q.size() != 0);
        rdy  = !full || ordy;
        check("out_valid", int'(out_valid), int'(full));
        check("in_ready", int'(in_ready), int'(rdy));
        check("byte_cnt", int'(byte_cnt), m_cnt);
        if (full) begin
            b = m_q[0] & 8'hFF;
            check("out_byte", int'(out_byte), b);
            check("out_padded", int'(out_padded), (m_q[0] >> 8) & 1);
`ifdef NIBBLE_PACKER_PARITY_EN
            check("out_parity", int'(out_parity), int'(^(8'(b))));
`endif
        end
        if (full && ordy) begin
            void'(m_q.pop_front());
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
        end
        if (v && rdy) begin
            if (m_half) begin
                m_q.push_back(form(m_first, nib & 15, m_ord));
                m_half = 0;
            end else begin
                m_half  = 1;
                m_first = nib & 15;
                m_ord   = hf;
            end
        end else if (fl && m_half) begin
            m_q.push_back(256 + form(m_first, 0, m_ord));
            m_half = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse in the middle of a cycle.
    task automatic do_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_byte", int'(out_byte), 0);
        check("rst_out_padded", int'(out_padded), 0);
        check("rst_byte_cnt", int'(byte_cnt), 0);
        check("rst_in_ready", int'(in_ready), 1);
`ifdef NIBBLE_PACKER_PARITY_EN
        check("rst_out_parity", int'(out_parity), 0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_nib    = 4'h0;
        hi_first  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_reset();

        // 1: A then 5, high first -> A5
        drive(1, 'hA, 1, 0, 1);
        drive(1, 'h5, 1, 0, 1);
        check("t1_byte", int'(out_byte), 'hA5);
`ifdef NIBBLE_PACKER_PARITY_EN
        check("t1_parity", int'(out_parity), 0);
`endif
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        check("t1_cnt", int'(byte_cnt), 1);

        // 2: low first, order toggled mid-pair -> C3
        drive(1, 'h3, 0, 0, 1);
        drive(1, 'hC, 1, 0, 1);
        check("t2_byte", int'(out_byte), 'hC3);
        drive(0, 0, 1, 0, 1);

        // 3: flush of a lone 7, then flush while empty
        drive(1, 'h7, 1, 0, 1);
        drive(0, 0, 0, 1, 1);
        check("t3_byte", int'(out_byte), 'h70);
        check("t3_pad", int'(out_padded), 1);
`ifdef NIBBLE_PACKER_PARITY_EN
        check("t3_parity", int'(out_parity), 1);
`endif
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 1);

        // 4: stall with 12 pending, then drain while taking F
        drive(1, 'h1, 1, 0, 0);
        drive(1, 'h2, 0, 0, 0);
        repeat (3) drive(1, 'hF, 1, 0, 0);
        check("t4_hold", int'(out_byte), 'h12);
        drive(1, 'hF, 1, 0, 1);
        check("t4_half", int'(out_valid), 0);
        drive(1, 'h4, 0, 0, 1);
        drive(0, 0, 0, 0, 1);

        // 5: continuous stream past the counter wrap
        for (int i = 0; i < 2 * ((1 << CNT_W) + 2); i++) begin
            drive(1, int'($urandom_range(15)), bit'($urandom_range(1)), 0, 1);
        end
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);

        // Random traffic with stalls and flushes
        for (int i = 0; i < 1500; i++) begin
            drive(bit'($urandom_range(1)), int'($urandom_range(15)),
                  bit'($urandom_range(1)), bit'($urandom_range(3) == 0),
                  bit'($urandom_range(2) != 0));
        end
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);

        // 6: reset while HALF, then while FULL, then a clean pair
        drive(1, 'h9, 1, 0, 1);
        do_reset();
        drive(1, 'h3, 1, 0, 0);
        drive(1, 'h8, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        do_reset();
        drive(1, 'hA, 1, 0, 1);
        drive(1, 'h5, 0, 0, 1);
        check("t6_byte", int'(out_byte), 'hA5);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
